// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: checker state encoding and default PRBS7 polynomial,
// used by both the generator and the checker so the two ends cannot diverge.
package prbs_pkg;

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } prbs_state_t;

  localparam int          PRBS7_WIDTH = 7;
  localparam logic [6:0]  PRBS7_TAPS  = 7'h60;  // x^7 + x^6 + 1

endpackage

// File: rtl/prbs_step.sv
// One LFSR step: predicted next bit and the free-running next state.
// Convention: pred = ^(s & TAPS), shift is {s[WIDTH-2:0], bit}.
module prbs_step
  import prbs_pkg::*;
#(
  parameter int               WIDTH = PRBS7_WIDTH,
  parameter logic [WIDTH-1:0] TAPS  = PRBS7_TAPS
) (
  input  logic [WIDTH-1:0] s,
  output logic             pred,
  output logic [WIDTH-1:0] s_next
);

  assign pred   = ^(s & TAPS);
  assign s_next = {s[WIDTH-2:0], pred};

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS checker: seeds from the stream, verifies LOCK_COUNT
// predictions, then free-runs and counts mismatches until sustained failure.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int               WIDTH       = PRBS7_WIDTH,
  parameter logic [WIDTH-1:0] TAPS        = PRBS7_TAPS,
  parameter int               LOCK_COUNT  = 16,
  parameter int               UNLOCK_ERRS = 4,
  parameter int               CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             err_clr,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [1:0]       state
);

  localparam int FILL_W  = $clog2(WIDTH + 1);
  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int RUN_W   = $clog2(UNLOCK_ERRS + 1);

  prbs_state_t        st, st_n;
  logic [WIDTH-1:0]   s, s_n, s_free, s_din;
  logic [FILL_W-1:0]  fill, fill_n;
  logic [MATCH_W-1:0] match, match_n;
  logic [RUN_W-1:0]   run, run_n;
  logic [CNT_W-1:0]   cnt_n;
  logic               pulse_n, pred, hit;

  prbs_step #(.WIDTH(WIDTH), .TAPS(TAPS)) u_step (
    .s      (s),
    .pred   (pred),
    .s_next (s_free)
  );

  assign s_din = {s[WIDTH-2:0], din};

  // din is a qualified stream with no back-pressure: a bit is consumed exactly
  // in cycles where din_valid is high; other cycles leave s and the FSM alone.
  always_comb begin
    st_n    = st;
    s_n     = s;
    fill_n  = fill;
    match_n = match;
    run_n   = run;
    pulse_n = 1'b0;
    hit     = 1'b0;
    if (din_valid) begin
      case (st)
        SEED: begin
          s_n = s_din;
          if (fill == FILL_W'(WIDTH - 1)) begin
            fill_n = '0;
            if (s_din != '0) begin
              st_n    = VERIFY;
              match_n = '0;
            end
          end else begin
            fill_n = fill + 1'b1;
          end
        end
        VERIFY: begin
          if (din == pred) begin
            s_n     = s_din;
            match_n = match + 1'b1;
            if (match == MATCH_W'(LOCK_COUNT - 1)) begin
              st_n  = LOCKED;
              run_n = '0;
            end
          end else begin
            st_n   = SEED;
            fill_n = '0;
          end
        end
        LOCKED: begin
          // Free-running on pred keeps a single line error to one mismatch.
          s_n = s_free;
          if (din != pred) begin
            hit     = 1'b1;
            pulse_n = 1'b1;
            if (run == RUN_W'(UNLOCK_ERRS - 1)) begin
              st_n   = SEED;
              fill_n = '0;
              run_n  = '0;
            end else begin
              run_n = run + 1'b1;
            end
          end else begin
            run_n = '0;
          end
        end
        default: begin
          st_n   = SEED;
          fill_n = '0;
        end
      endcase
    end

    cnt_n = err_count;
    if (err_clr)
      cnt_n = hit ? CNT_W'(1) : '0;
    else if (hit && (err_count != {CNT_W{1'b1}}))
      cnt_n = err_count + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= SEED;
      s         <= '0;
      fill      <= '0;
      match     <= '0;
      run       <= '0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      st        <= st_n;
      s         <= s_n;
      fill      <= fill_n;
      match     <= match_n;
      run       <= run_n;
      err_pulse <= pulse_n;
      err_count <= cnt_n;
    end
  end

  assign locked = (st == LOCKED);
  assign state  = st;

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: a reference PRBS source drives the checker and a
// bit-history model of the lock/verify rules predicts every output each cycle.
module tb_prbs_checker;

  localparam int         W    = 7;
  localparam logic [6:0] TP   = 7'h60;
  localparam int         LOCK = 16;
  localparam int         UNL  = 4;

  logic        clk = 1'b0;
  logic        rst, din, din_valid, err_clr;
  logic        locked, err_pulse, locked2, err_pulse2;
  logic [15:0] err_count;
  logic [1:0]  err_count2, state, state2;

  int n_tests = 0;
  int n_fail  = 0;

  prbs_checker dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .err_clr(err_clr),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .state(state)
  );

  prbs_checker #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .err_clr(err_clr),
    .locked(locked2), .err_pulse(err_pulse2), .err_count(err_count2), .state(state2)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int   m_state, m_match, m_run, m_cnt, m_cnt2;
  bit   m_pulse;
  bit   m_hist[$];
  logic [6:0] g;

  task automatic gen(output bit b);
    g = {g[5:0], ^(g & TP)};
    b = g[0];
  endtask

  function automatic bit m_pred();
    bit p = 1'b0;
    for (int i = 0; i < W; i++)
      if (TP[i]) p ^= m_hist[m_hist.size() - 1 - i];
    return p;
  endfunction

  task automatic model_reset();
    m_state = 0; m_match = 0; m_run = 0; m_cnt = 0; m_cnt2 = 0; m_pulse = 1'b0;
    m_hist.delete();
  endtask

  task automatic model_step(input bit v, input bit d, input bit clr);
    bit hit = 1'b0;
    bit p;
    int ones;
    m_pulse = 1'b0;
    if (v) begin
      case (m_state)
        0: begin
          m_hist.push_back(d);
          if (m_hist.size() == W) begin
            ones = 0;
            foreach (m_hist[i]) ones += int'(m_hist[i]);
            if (ones == 0) m_hist.delete();
            else begin m_state = 1; m_match = 0; end
          end
        end
        1: begin
          if (d == m_pred()) begin
            m_hist.push_back(d);
            void'(m_hist.pop_front());
            m_match++;
            if (m_match == LOCK) begin m_state = 2; m_run = 0; end
          end else begin
            m_state = 0;
            m_hist.delete();
          end
        end
        default: begin
          p = m_pred();
          m_hist.push_back(p);
          void'(m_hist.pop_front());
          if (d != p) begin
            hit = 1'b1; m_pulse = 1'b1; m_run++;
            if (m_run == UNL) begin m_state = 0; m_hist.delete(); m_run = 0; end
          end else m_run = 0;
        end
      endcase
    end
    if (clr) begin
      m_cnt = int'(hit); m_cnt2 = int'(hit);
    end else if (hit) begin
      m_cnt  = (m_cnt  < 65535) ? m_cnt + 1  : m_cnt;
      m_cnt2 = (m_cnt2 < 3)     ? m_cnt2 + 1 : m_cnt2;
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("locked",     32'(locked),     32'(m_state == 2));
    check("err_pulse",  32'(err_pulse),  32'(m_pulse));
    check("err_count",  32'(err_count),  32'(m_cnt));
    check("state",      32'(state),      32'(m_state));
    check("locked2",    32'(locked2),    32'(m_state == 2));
    check("err_count2", 32'(err_count2), 32'(m_cnt2));
  endtask

  // ---------------- drivers ----------------
  task automatic cycle(input bit v, input bit d, input bit clr);
    din_valid = v; din = d; err_clr = clr;
    @(posedge clk); #1;
    model_step(v, d, clr);
    compare_all();
    din_valid = 1'b0; err_clr = 1'b0;
  endtask

  task automatic clean(input int n);
    bit b;
    repeat (n) begin gen(b); cycle(1'b1, b, 1'b0); end
  endtask

  task automatic flip_bits(input int n);
    bit b;
    repeat (n) begin gen(b); cycle(1'b1, ~b, 1'b0); end
  endtask

  task automatic do_reset();
    rst = 1'b1; din = 1'b0; din_valid = 1'b0; err_clr = 1'b0;
    @(posedge clk); #1;
    model_reset();
    compare_all();
    rst = 1'b0;
  endtask

  task automatic bits_to_lock(output int k);
    bit b;
    k = 0;
    for (int i = 0; i < 300 && !locked; i++) begin
      gen(b); cycle(1'b1, b, 1'b0); k++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int  k, cyc;
    bit  b, v, f, c;
    int  burst;

    // Continuous valid stream, seed 7'h01
    do_reset();
    g = 7'h01;
    bits_to_lock(k);
    check("lock_bits_cont", 32'(k), 32'd23);
    clean(1000 - k);
    check("cont_err_count", 32'(err_count), 32'd0);
    check("cont_state", 32'(state), 32'd2);

    // din_valid toggling: invalid cycles carry junk and must not advance s
    do_reset();
    g = 7'h01;
    cyc = 0;
    for (int i = 0; i < 300 && !locked; i++) begin
      cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      gen(b); cycle(1'b1, b, 1'b0);
      cyc += 2;
    end
    check("lock_cycles_toggle", 32'(cyc), 32'd46);

    // Single flipped bit while locked
    flip_bits(1);
    check("single_pulse",  32'(err_pulse), 32'd1);
    check("single_count",  32'(err_count), 32'd1);
    check("single_locked", 32'(locked),    32'd1);
    clean(127);
    check("single_after_count",  32'(err_count), 32'd1);
    check("single_after_locked", 32'(locked),    32'd1);

    // Four consecutive flips force resync; count survives loss of lock
    cycle(1'b0, 1'b0, 1'b1);
    check("clr_alone", 32'(err_count), 32'd0);
    flip_bits(3);
    check("burst3_locked", 32'(locked), 32'd1);
    flip_bits(1);
    check("burst4_pulse",  32'(err_pulse), 32'd1);
    check("burst4_locked", 32'(locked),    32'd0);
    check("burst4_state",  32'(state),     32'd0);
    check("burst4_count",  32'(err_count), 32'd4);
    bits_to_lock(k);
    check("relock_bits",  32'(k),         32'd23);
    check("relock_count", 32'(err_count), 32'd4);

    // err_clr coincident with a counted error
    gen(b); cycle(1'b1, ~b, 1'b1);
    check("clr_with_err", 32'(err_count), 32'd1);
    clean(2);

    // Five isolated errors saturate the 2-bit counter at 3
    cycle(1'b0, 1'b0, 1'b1);
    repeat (5) begin flip_bits(1); clean(3); end
    check("sat_count2", 32'(err_count2), 32'd3);
    check("sat_count16", 32'(err_count), 32'd5);
    check("sat_locked", 32'(locked), 32'd1);

    // Asynchronous reset mid-LOCKED
    #2;
    rst = 1'b1;
    #1;
    check("async_locked", 32'(locked),    32'd0);
    check("async_pulse",  32'(err_pulse), 32'd0);
    check("async_count",  32'(err_count), 32'd0);
    check("async_state",  32'(state),     32'd0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    bits_to_lock(k);
    check("async_relock_bits", 32'(k), 32'd23);

    // All-zero stream never seeds
    do_reset();
    repeat (200) cycle(1'b1, 1'b0, 1'b0);
    check("zero_locked", 32'(locked), 32'd0);
    check("zero_state",  32'(state),  32'd0);

    // Randomized traffic: gaps, sparse errors, occasional bursts and clears
    do_reset();
    g = 7'($urandom_range(1, 127));
    burst = 0;
    repeat (3000) begin
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 199) == 0);
      if (burst == 0 && $urandom_range(0, 499) == 0) burst = 5;
      if (v) begin
        f = (burst > 0) || ($urandom_range(0, 99) < 2);
        if (burst > 0) burst--;
        gen(b);
        cycle(1'b1, b ^ f, c);
      end else begin
        cycle(1'b0, 1'($urandom_range(0, 1)), c);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/prbs_checker.md
Name: prbs_checker

Overview:
- Receive-side counterpart of the on-board LFSR pseudo-random generator: consumes a serial PRBS bit stream (e.g. looped back through a PMOD pin) and self-synchronises to it.
- Once locked, predicts each bit, flags and counts mismatches, and drops lock on sustained failure.
- Sits in chip-level designs beside the generator; status drives LEDs or a debug port.

Parameters:
- WIDTH, 7, LFSR length in bits (generator state width).
- TAPS, 7'h60, feedback mask. Default is PRBS7 x^7+x^6+1. Must equal the generator's mask.
- LOCK_COUNT, 16, consecutive correct predictions required to declare lock.
- UNLOCK_ERRS, 4, consecutive mismatches while locked that force resync.
- CNT_W, 16, width of the error counter.

Ports:
- clk  input  1  system clock (100 MHz)
- rst  input  1  asynchronous active-high reset
- din  input  1  received PRBS bit
- din_valid  input  1  din is sampled only in cycles where this is high
- err_clr  input  1  synchronous clear of err_count
- locked  output  1  high while in LOCKED state
- err_pulse  output  1  one-cycle pulse per mismatch detected in LOCKED
- err_count  output  CNT_W  saturating mismatch count since reset/clear
- state  output  2  current FSM state for debug (SEED=0, VERIFY=1, LOCKED=2)

Behaviour:
- Reset (async, active-high), all outputs and state cleared:
  - shift register s = 0, fill/match/err-run counters = 0
  - state = SEED, locked = 0, err_pulse = 0, err_count = 0
- Convention, shared with the generator:
  - pred = ^(s & TAPS)
  - shift is s <= {s[WIDTH-2:0], bit}
- Cycles with din_valid = 0 change nothing except err_pulse returning to 0 and err_clr acting.
- SEED:
  - Each valid bit shifts din into s and increments fill.
  - After WIDTH valid bits: if the resulting s == 0, stay in SEED with fill = 0, since the all-zero seed is rejected. Otherwise go to VERIFY with match = 0.
- VERIFY:
  - Each valid bit is compared with pred. Match shifts din in and increments match.
  - On mismatch: go to SEED, fill = 0. No err_pulse, no count.
  - match reaching LOCK_COUNT moves to LOCKED. locked rises the cycle after the LOCK_COUNT-th matching bit.
- LOCKED:
  - s free-runs on pred (never on din), so a single-bit line error yields exactly one mismatch.
  - Each valid bit: if din != pred, err_pulse = 1 next cycle, err_count increments (saturating at all-ones), and run increments. Otherwise run = 0.
  - run reaching UNLOCK_ERRS: next state SEED, locked falls the same cycle as that error's err_pulse, fill = 0.
- Latency: all outputs registered. Effect of a valid bit is visible the cycle after it is sampled.
- Minimum lock time: WIDTH + LOCK_COUNT valid bits (23 for defaults).
- err_clr with a simultaneous counted error: err_count = 1.
- err_clr alone: err_count = 0 next cycle.
- err_count is not cleared by loss of lock.
- Reset asserted mid-operation (any state) returns to reset values immediately. The first valid bit after deassertion is seed bit 0.
- Width rules: fill counter is clog2(WIDTH+1), match is clog2(LOCK_COUNT+1), run is clog2(UNLOCK_ERRS+1). None wrap; each is bounded by its transition.

Decomposition:
- Shared package/include prbs_pkg holds:
  - state encodings SEED/VERIFY/LOCKED
  - default PRBS7 constants (WIDTH=7, TAPS=7'h60)
  - so generator and checker cannot diverge
- Sub-module: prbs_step (combinational), taking s and TAPS and producing pred and next-state. The generator reuses it so both ends share the same polynomial convention.
- Top-level FSM and counters stay in prbs_checker.

Test Plan:
- Generator seeded 7'h01, din_valid = 1 continuously: locked = 1 exactly one cycle after the 23rd bit, err_count = 0 over 1000 bits, state = 2.
- Same stream with din_valid toggling 1/0 every cycle: lock after 23 valid bits (46 cycles). No errors; invalid cycles do not advance s.
- Locked, then flip one bit:
  - err_pulse high one cycle, err_count = 1
  - locked stays 1
  - next 127 bits produce no further errors
- Locked, then flip 4 consecutive bits:
  - err_count = 4
  - locked falls with the 4th err_pulse, state = 0
  - after 23 more clean bits, locked = 1 again
  - err_count still 4
- Constant din = 0: first 7 bits give s = 0, so the checker stays in SEED forever and locked never asserts.
- Reset boundaries:
  - Assert rst mid-LOCKED: outputs zero asynchronously; relock after 23 bits.
  - With CNT_W = 2 and 5 single errors, err_count saturates at 3.
  - err_clr coincident with an error gives err_count = 1.
